// File: rtl/vga_console_wr_sched_pkg.sv
// Shared definitions for the VGA console write scheduler: character width,
// console control codes and drain-FSM state encodings.
package vga_console_wr_sched_pkg;

    localparam int CHAR_W = 8;

    // Control codes travel through the scheduler verbatim; the console interprets them.
    localparam logic [CHAR_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [CHAR_W-1:0] ASCII_BS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/vga_console_wr_sched_char_fifo.sv
// Synchronous character FIFO with synchronous flush; head byte is registered
// on pop so it lines up with the console strobe one cycle later.
module console_char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_console_wr_sched.sv
// Round-robin merge of CPU and debug character streams into a FIFO, drained to
// the VGA console as single-cycle writes that respect scroll and a minimum gap.
//
// state    | meaning
// IDLE     | waiting for a queued byte with scroll low; pops the head
// ISSUE    | font_we high for one cycle with the popped byte
// GAP      | forced idle cycles after a write, scroll ignored
module vga_console_wr_sched
    import vga_console_wr_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    parameter int MIN_GAP    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    input  logic [CHAR_W-1:0] cpu_data,
    output logic              cpu_ready,
    input  logic              dbg_valid,
    input  logic [CHAR_W-1:0] dbg_data,
    output logic              dbg_ready,
    input  logic              flush,
    input  logic              scroll,
    output logic              font_we,
    output logic [CHAR_W-1:0] font_data,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       GAP_LOAD = 4'(MIN_GAP);

    drain_state_e      state_q;
    logic [3:0]        gap_q;
    logic              font_we_q;
    logic              prio_q;
    logic              space;
    logic              push;
    logic              pop;
    logic [CHAR_W-1:0] push_data;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign space     = resetn && (fifo_count != FULL_CNT) && !flush;
    assign cpu_ready = space && cpu_valid && (!dbg_valid || !prio_q);
    assign dbg_ready = space && dbg_valid && (!cpu_valid ||  prio_q);
    assign push      = cpu_ready || dbg_ready;
    assign push_data = cpu_ready ? cpu_data : dbg_data;

    assign pop = (state_q == ST_IDLE) && (fifo_count != '0) && !scroll && !flush;

    console_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .count_o     (fifo_count),
        .rd_data_o   (font_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else if (cpu_ready) begin
            prio_q <= 1'b1;
        end else if (dbg_ready) begin
            prio_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            font_we_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    font_we_q <= 1'b0;
                    if (pop) begin
                        state_q   <= ST_ISSUE;
                        font_we_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    font_we_q <= 1'b0;
                    gap_q     <= GAP_LOAD;
                    state_q   <= (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    font_we_q <= 1'b0;
                    gap_q     <= gap_q - 1'b1;
                    if (gap_q <= 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    font_we_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign font_we = font_we_q;
    assign busy    = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_console_wr_sched.sv
// Directed bench for vga_console_wr_sched (FIFO_DEPTH=16, MIN_GAP=1) with
// hand-computed expectations.
module tb_vga_console_wr_sched;
    import vga_console_wr_sched_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CNT_W   = 5;
    localparam int MIN_GAP = 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cpu_valid;
    logic [7:0]       cpu_data;
    logic             cpu_ready;
    logic             dbg_valid;
    logic [7:0]       dbg_data;
    logic             dbg_ready;
    logic             flush;
    logic             scroll;
    logic             font_we;
    logic [7:0]       font_data;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;

    int checks;
    int failures;
    int cyc;
    int nstrobe;
    logic [7:0] sb_data [16];
    int         sb_cyc  [16];

    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vga_console_wr_sched #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_valid  (cpu_valid),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready),
        .flush      (flush),
        .scroll     (scroll),
        .font_we    (font_we),
        .font_data  (font_data),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        flush     = 1'b0;
        scroll    = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        nstrobe = 0;
        for (int i = 0; i < budget && nstrobe < n; i++) begin
            @(negedge clk);
            if (font_we) begin
                sb_data[nstrobe] = font_data;
                sb_cyc[nstrobe]  = cyc;
                nstrobe++;
            end
        end
        chk("strobe_count", nstrobe, n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    logic [7:0] exp_stream [8];
    logic [7:0] exp_ctrl   [3];
    int  acc, nwe, s_fall, ci, di;
    logic cr, dr, seen;

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stream = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h32, 8'h63, 8'h33, 8'h64};
        exp_ctrl   = '{ASCII_CR, ASCII_LF, ASCII_BS};

        // Reset values, with a requester already presenting a byte
        resetn    = 1'b0;
        cpu_valid = 1'b1;
        cpu_data  = 8'h41;
        dbg_valid = 1'b0;
        dbg_data  = 8'h00;
        flush     = 1'b0;
        scroll    = 1'b0;
        #12;
        chk("rst_font_we",   32'(font_we), 0);
        chk("rst_font_data", 32'(font_data), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_count",     32'(fifo_count), 0);
        chk("rst_cpu_ready", 32'(cpu_ready), 0);
        cpu_valid = 1'b0;
        #5 resetn = 1'b1;
        step();

        // Single byte: accept in cycle 0, strobe in cycle 2, idle by cycle 4
        cpu_valid = 1'b1;
        cpu_data  = 8'h41;
        @(negedge clk);
        chk("single_ready", 32'(cpu_ready), 1);
        step();
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("single_c1_we",    32'(font_we), 0);
        chk("single_c1_count", 32'(fifo_count), 1);
        chk("single_c1_busy",  32'(busy), 1);
        step();
        @(negedge clk);
        chk("single_we",   32'(font_we), 1);
        chk("single_data", 32'(font_data), 32'h41);
        step();
        @(negedge clk);
        chk("single_gap_we",   32'(font_we), 0);
        chk("single_gap_busy", 32'(busy), 1);
        step();
        @(negedge clk);
        chk("single_idle_busy", 32'(busy), 0);

        // Both requesters streaming from a fresh reset (priority on req 0)
        do_reset();
        step();
        fork
            begin
                ci = 0;
                di = 0;
                cpu_valid = 1'b1;
                dbg_valid = 1'b1;
                cpu_data  = 8'h30;
                dbg_data  = 8'h61;
                for (int k = 0; k < 40 && (ci < 4 || di < 4); k++) begin
                    @(negedge clk);
                    cr = cpu_ready;
                    dr = dbg_ready;
                    step();
                    if (cr) ci++;
                    if (dr) di++;
                    cpu_valid = (ci < 4);
                    cpu_data  = 8'(8'h30 + ci);
                    dbg_valid = (di < 4);
                    dbg_data  = 8'(8'h61 + di);
                end
                cpu_valid = 1'b0;
                dbg_valid = 1'b0;
            end
            collect(8, 100);
        join
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_byte%0d", i), 32'(sb_data[i]), 32'(exp_stream[i]));
        end
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("stream_gap%0d", i), sb_cyc[i] - sb_cyc[i-1], 3);
        end
        wait_idle();

        // Fill under scroll: exactly 16 accepts, then no slot even on the pop cycle
        do_reset();
        step();
        scroll    = 1'b1;
        dbg_valid = 1'b1;
        dbg_data  = 8'h40;
        acc = 0;
        nwe = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (font_we) nwe++;
            dr = dbg_ready;
            step();
            if (dr) acc++;
            dbg_data = 8'(8'h40 + acc);
        end
        @(negedge clk);
        chk("fill_accepts", acc, 16);
        chk("fill_count",   32'(fifo_count), 16);
        chk("fill_ready",   32'(dbg_ready), 0);
        chk("fill_no_we",   nwe, 0);
        step();
        scroll = 1'b0;
        @(negedge clk);
        chk("fill_pop_ready", 32'(dbg_ready), 0);
        step();
        @(negedge clk);
        chk("fill_issue_we",    32'(font_we), 1);
        chk("fill_issue_data",  32'(font_data), 32'h40);
        chk("fill_issue_count", 32'(fifo_count), 15);
        chk("fill_issue_ready", 32'(dbg_ready), 1);
        step();
        dbg_valid = 1'b0;

        // Scroll hold: three control codes queued, scroll high for 50 cycles
        do_reset();
        step();
        scroll    = 1'b1;
        cpu_valid = 1'b1;
        cpu_data  = ASCII_CR;
        step();
        cpu_data  = ASCII_LF;
        step();
        cpu_data  = ASCII_BS;
        step();
        cpu_valid = 1'b0;
        nwe = 0;
        for (int k = 0; k < 47; k++) begin
            @(negedge clk);
            if (font_we) nwe++;
            step();
        end
        chk("scroll_no_we", nwe, 0);
        chk("scroll_count", 32'(fifo_count), 3);
        scroll = 1'b0;
        s_fall = cyc;
        collect(3, 30);
        chk("scroll_first_latency", sb_cyc[0] - (s_fall - 1), 2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("scroll_byte%0d", i), 32'(sb_data[i]), 32'(exp_ctrl[i]));
        end
        chk("scroll_gap", sb_cyc[2] - sb_cyc[1], 3);
        wait_idle();

        // Flush during GAP with five bytes queued
        do_reset();
        step();
        scroll    = 1'b1;
        cpu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_data = 8'(8'h50 + i);
            step();
        end
        cpu_valid = 1'b0;
        scroll    = 1'b0;
        step();
        @(negedge clk);
        chk("flush_we",   32'(font_we), 1);
        chk("flush_data", 32'(font_data), 32'h50);
        step();
        flush     = 1'b1;
        cpu_valid = 1'b1;
        cpu_data  = 8'h5A;
        @(negedge clk);
        chk("flush_gap_count", 32'(fifo_count), 4);
        chk("flush_ready",     32'(cpu_ready), 0);
        chk("flush_gap_we",    32'(font_we), 0);
        step();
        flush     = 1'b0;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_busy",  32'(busy), 0);
        nwe = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (font_we) nwe++;
        end
        chk("flush_no_we", nwe, 0);

        // Asynchronous reset in the middle of a drain
        do_reset();
        step();
        cpu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_data = 8'(8'h60 + i);
            step();
        end
        cpu_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (font_we) seen = 1'b1;
        end
        chk("arst_saw_strobe", 32'(seen), 1);
        resetn = 1'b0;
        #1;
        chk("arst_we",    32'(font_we), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_busy",  32'(busy), 0);
        #13 resetn = 1'b1;
        step();
        nwe = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (font_we) nwe++;
        end
        chk("arst_no_we", nwe, 0);
        step();
        cpu_valid = 1'b1;
        cpu_data  = 8'h70;
        dbg_valid = 1'b1;
        dbg_data  = 8'h71;
        @(negedge clk);
        chk("arst_prio_cpu", 32'(cpu_ready), 1);
        chk("arst_prio_dbg", 32'(dbg_ready), 0);
        step();
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        collect(1, 10);
        chk("arst_first_data", 32'(sb_data[0]), 32'h70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
